// File: rtl/snake_pkg.sv
// Shared definitions for the snake game front end.
//   game_mode      : top-level mode encoding (MENU / ERROR / GAME / ENDSCR)
//   button geometry: screen rectangles of the three menu buttons and the error button
//   BUTTON_*       : hover / button-id encodings
//   ERR_*          : error codes shown on the error screen
//   in_rect()      : point-in-rectangle test, low edges inclusive, high edges exclusive
package snake_pkg;

    typedef enum logic [1:0] {
        MENU   = 2'd0,
        ERROR  = 2'd1,
        GAME   = 2'd2,
        ENDSCR = 2'd3
    } game_mode;

    // Button geometry. The three menu buttons share one column; the error
    // button sits in the same column and is only live on the error screen.
    localparam logic [11:0] BUTTONS_X = 12'd400;
    localparam logic [11:0] BUTTONS_W = 12'd200;
    localparam logic [11:0] BUTTONS_H = 12'd60;
    localparam logic [11:0] BUTTON1_Y = 12'd200;
    localparam logic [11:0] BUTTON2_Y = 12'd300;
    localparam logic [11:0] BUTTON3_Y = 12'd400;
    localparam logic [11:0] BUTTONE_Y = 12'd350;

    localparam logic [1:0] BUTTON_NONE  = 2'd0;
    localparam logic [1:0] BUTTON_START = 2'd1;
    localparam logic [1:0] BUTTON_SOLO  = 2'd2;
    localparam logic [1:0] BUTTON_SPEED = 2'd3;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_NOLINK = 2'd1;

    // Five seconds at 65 MHz.
    localparam int unsigned ENDSCR_TICKS_DEF = 32'd325_000_000;

    // The far edges are formed in 13 bits so a rectangle touching the top of
    // the 12-bit range cannot wrap around and swallow small coordinates.
    function automatic logic in_rect(input logic [11:0] x,  input logic [11:0] y,
                                     input logic [11:0] rx, input logic [11:0] ry,
                                     input logic [11:0] rw, input logic [11:0] rh);
        logic [12:0] x_end;
        logic [12:0] y_end;
        x_end = {1'b0, rx} + {1'b0, rw};
        y_end = {1'b0, ry} + {1'b0, rh};
        return (x >= rx) && ({1'b0, x} < x_end) &&
               (y >= ry) && ({1'b0, y} < y_end);
    endfunction

endpackage

// File: rtl/snake_click_det.sv
// Mouse click detector.
//   clk, rst_n : system clock, asynchronous active-low reset
//   left       : raw mouse left-button level (asynchronous)
//   click      : one-cycle pulse, at most one per press
// The button level passes a two-flop synchroniser. A click fires on the
// synchronised high while armed; arming returns only after a synchronised low,
// so a held button never produces a second click.
module snake_click_det (
    input  logic clk,
    input  logic rst_n,
    input  logic left,
    output logic click
);

    logic sync1;
    logic sync2;
    logic armed;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the synchroniser depends on it).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            armed <= 1'b1;
            click <= 1'b0;
        end else begin
            sync1 <= left;
            sync2 <= sync1;
            click <= sync2 && armed;
            if (sync2 && armed) begin
                armed <= 1'b0;
            end else if (!sync2) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_mode_ctrl.sv
// Top-level game-mode sequencer.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   xpos, ypos  : mouse pointer, already in the clk domain
//   left        : mouse left-button level, asynchronous
//   link_up     : remote player link established
//   game_over   : end of round from the game core (level)
//   mode        : current mode (MENU / ERROR / GAME / ENDSCR)
//   hover       : button under the pointer (menu buttons 1..3, or 1 = error button)
//   solo        : single-player option
//   speed       : difficulty 0..3
//   start_game  : one-cycle pulse on MENU -> GAME
//   err_code    : ERR_NONE / ERR_NOLINK
module snake_mode_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned ENDSCR_TICKS = ENDSCR_TICKS_DEF,
    parameter int          CNT_W        = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    input  logic        left,
    input  logic        link_up,
    input  logic        game_over,
    output game_mode    mode,
    output logic [1:0]  hover,
    output logic        solo,
    output logic [1:0]  speed,
    output logic        start_game,
    output logic [1:0]  err_code
);

    logic             click;
    logic [1:0]       hit_menu;
    logic             hit_err;
    logic [CNT_W-1:0] cnt;

    game_mode         mode_next;
    logic             solo_next;
    logic [1:0]       speed_next;
    logic             start_next;
    logic [1:0]       err_next;
    logic [CNT_W-1:0] cnt_next;
    logic             timeout;

    snake_click_det u_click_det (
        .clk   (clk),
        .rst_n (rst_n),
        .left  (left),
        .click (click)
    );

    // Hit test is registered for both screens independently; the mode only
    // gates which result is shown, so hover is 0 from the very first GAME cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_menu <= BUTTON_NONE;
            hit_err  <= 1'b0;
        end else begin
            if (in_rect(xpos, ypos, BUTTONS_X, BUTTON1_Y, BUTTONS_W, BUTTONS_H)) begin
                hit_menu <= BUTTON_START;
            end else if (in_rect(xpos, ypos, BUTTONS_X, BUTTON2_Y, BUTTONS_W, BUTTONS_H)) begin
                hit_menu <= BUTTON_SOLO;
            end else if (in_rect(xpos, ypos, BUTTONS_X, BUTTON3_Y, BUTTONS_W, BUTTONS_H)) begin
                hit_menu <= BUTTON_SPEED;
            end else begin
                hit_menu <= BUTTON_NONE;
            end
            hit_err <= in_rect(xpos, ypos, BUTTONS_X, BUTTONE_Y, BUTTONS_W, BUTTONS_H);
        end
    end

    // State register: mode plus the option/flag registers it owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode       <= MENU;
            solo       <= 1'b0;
            speed      <= 2'd1;
            start_game <= 1'b0;
            err_code   <= ERR_NONE;
            cnt        <= '0;
        end else begin
            mode       <= mode_next;
            solo       <= solo_next;
            speed      <= speed_next;
            start_game <= start_next;
            err_code   <= err_next;
            cnt        <= cnt_next;
        end
    end

    assign timeout = (cnt == CNT_W'(ENDSCR_TICKS - 1));

    // Next-state logic.
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        mode_next  = mode;
        solo_next  = solo;
        speed_next = speed;
        start_next = 1'b0;
        err_next   = err_code;
        cnt_next   = cnt;
        case (mode)
            MENU: begin
                if (click) begin
                    case (hover)
                        BUTTON_START: begin
                            if (solo || link_up) begin
                                mode_next  = GAME;
                                start_next = 1'b1;
                            end else begin
                                mode_next = ERROR;
                                err_next  = ERR_NOLINK;
                            end
                        end
                        BUTTON_SOLO:  solo_next  = ~solo;
                        BUTTON_SPEED: speed_next = speed + 2'd1;
                        default: ;
                    endcase
                end
            end
            ERROR: begin
                if (click && hover == BUTTON_START) begin
                    mode_next = MENU;
                    err_next  = ERR_NONE;
                end
            end
            GAME: begin
                // game_over takes priority over a simultaneous link drop.
                if (game_over) begin
                    mode_next = ENDSCR;
                    cnt_next  = '0;
                end else if (!link_up && !solo) begin
                    mode_next = ERROR;
                    err_next  = ERR_NOLINK;
                end
            end
            ENDSCR: begin
                cnt_next = cnt + 1'b1;
                if (click || timeout) begin
                    mode_next = MENU;
                end
            end
            default: mode_next = MENU;
        endcase
    end

    // Output logic: hover is only meaningful on the menu and error screens.
    always_comb begin
        hover = BUTTON_NONE;
        case (mode)
            MENU:    hover = hit_menu;
            ERROR:   hover = hit_err ? BUTTON_START : BUTTON_NONE;
            default: hover = BUTTON_NONE;
        endcase
    end

endmodule

// File: tb/tb_snake_mode_ctrl.sv
// Self-checking bench for snake_mode_ctrl. A behavioural model predicts every
// output each cycle; directed steps add literal expectations that pin the model.
module tb_snake_mode_ctrl;
    import snake_pkg::*;

    localparam int TICKS = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        left;
    logic        link_up;
    logic        game_over;
    game_mode    mode;
    logic [1:0]  hover;
    logic        solo;
    logic [1:0]  speed;
    logic        start_game;
    logic [1:0]  err_code;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int start_cnt = 0;

    always #5 clk = ~clk;

    snake_mode_ctrl #(.ENDSCR_TICKS(TICKS), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .xpos       (xpos),
        .ypos       (ypos),
        .left       (left),
        .link_up    (link_up),
        .game_over  (game_over),
        .mode       (mode),
        .hover      (hover),
        .solo       (solo),
        .speed      (speed),
        .start_game (start_game),
        .err_code   (err_code)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Modes as plain integers: 0 menu, 1 error, 2 game, 3 end screen.
    int m_mode, m_solo, m_speed, m_err, m_start, m_cnt;
    int m_menu_btn, m_err_btn;          // button under the pointer last cycle
    int m_seen1, m_seen2, m_armed, m_click;

    function automatic int inside_btn(int x, int y, int by);
        return (x >= 400 && x < 600 && y >= by && y < by + 60) ? 1 : 0;
    endfunction

    function automatic int exp_hover();
        if (m_mode == 0) return m_menu_btn;
        if (m_mode == 1) return m_err_btn;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = 0; m_solo = 0; m_speed = 1; m_err = 0; m_start = 0; m_cnt = 0;
            m_menu_btn = 0; m_err_btn = 0;
            m_seen1 = 0; m_seen2 = 0; m_armed = 1; m_click = 0;
        end else begin
            int h, c;
            h = exp_hover();
            c = m_click;
            m_start = 0;
            case (m_mode)
                0: if (c == 1) begin
                    if (h == 1) begin
                        if (m_solo == 1 || link_up) begin m_mode = 2; m_start = 1; end
                        else begin m_mode = 1; m_err = 1; end
                    end else if (h == 2) m_solo = 1 - m_solo;
                    else if (h == 3) m_speed = (m_speed + 1) % 4;
                end
                1: if (c == 1 && h == 1) begin m_mode = 0; m_err = 0; end
                2: if (game_over) begin m_mode = 3; m_cnt = 0; end
                   else if (!link_up && m_solo == 0) begin m_mode = 1; m_err = 1; end
                default: begin
                    if (c == 1 || m_cnt == TICKS - 1) m_mode = 0;
                    m_cnt = m_cnt + 1;
                end
            endcase
            // Button seen through two sync stages; one click per press.
            m_click = (m_seen2 == 1 && m_armed == 1) ? 1 : 0;
            if (m_click == 1) m_armed = 0;
            else if (m_seen2 == 0) m_armed = 1;
            m_seen2 = m_seen1;
            m_seen1 = left ? 1 : 0;
            if (inside_btn(xpos, ypos, 200) == 1)      m_menu_btn = 1;
            else if (inside_btn(xpos, ypos, 300) == 1) m_menu_btn = 2;
            else if (inside_btn(xpos, ypos, 400) == 1) m_menu_btn = 3;
            else                                       m_menu_btn = 0;
            m_err_btn = inside_btn(xpos, ypos, 350);
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (start_game) start_cnt++;
        if (cmp_en) begin
            check("mode",       int'(mode),     m_mode);
            check("hover",      int'(hover),    exp_hover());
            check("solo",       int'(solo),     m_solo);
            check("speed",      int'(speed),    m_speed);
            check("start_game", int'(start_game), m_start);
            check("err_code",   int'(err_code), m_err);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pos(input int x, input int y);
        xpos = 12'(x);
        ypos = 12'(y);
        step(2);
    endtask

    task automatic press(input int hold);
        left = 1'b1;
        step(hold);
        left = 1'b0;
        step(6);
    endtask

    initial begin
        int n;
        rst_n = 1'b0; left = 1'b0; link_up = 1'b0; game_over = 1'b0;
        xpos = '0; ypos = '0;
        step(3);
        rst_n = 1'b1;
        step(2);
        cmp_en = 1'b1;
        check("reset mode", int'(mode), 0);
        check("reset speed", int'(speed), 1);
        check("reset solo", int'(solo), 0);

        // Start with link.
        link_up = 1'b1;
        set_pos(400, 200);
        check("hover start", int'(hover), 1);
        press(2);
        check("start mode", int'(mode), 2);
        check("start pulses", start_cnt, 1);
        check("hover in game", int'(hover), 0);

        // Reset mid-game.
        cmp_en = 1'b0;
        rst_n = 1'b0;
        step(2);
        check("reset mid-game mode", int'(mode), 0);
        rst_n = 1'b1;
        step(2);
        cmp_en = 1'b1;
        check("no pulse after reset", start_cnt, 1);
        check("speed after reset", int'(speed), 1);

        // No link -> error, then back via the error button.
        link_up = 1'b0;
        press(2);
        check("error mode", int'(mode), 1);
        check("error code", int'(err_code), 1);
        set_pos(400, 350);
        check("hover error btn", int'(hover), 1);
        press(2);
        check("error exit mode", int'(mode), 0);
        check("error cleared", int'(err_code), 0);

        // Rectangle edges.
        set_pos(600, 200);
        check("hover x exclusive", int'(hover), 0);
        set_pos(599, 259);
        check("hover x,y inclusive", int'(hover), 1);
        set_pos(599, 260);
        check("hover y exclusive", int'(hover), 0);

        // Speed wraps.
        set_pos(450, 400);
        press(2); check("speed 2", int'(speed), 2);
        press(2); check("speed 3", int'(speed), 3);
        press(2); check("speed 0", int'(speed), 0);
        press(2); check("speed 1", int'(speed), 1);

        // Long press -> single increment.
        press(1000);
        check("held press speed", int'(speed), 2);

        // Press held across MENU -> ERROR does not click in ERROR.
        set_pos(450, 210);
        left = 1'b1;
        step(10);
        check("held into error", int'(mode), 1);
        set_pos(450, 360);
        step(20);
        left = 1'b0;
        step(6);
        check("still error", int'(mode), 1);
        press(2);
        check("back to menu", int'(mode), 0);

        // Solo toggle, solo start without link, link loss ignored in solo.
        set_pos(450, 300);
        press(2);
        check("solo on", int'(solo), 1);
        set_pos(450, 200);
        press(2);
        check("solo game", int'(mode), 2);
        step(5);
        check("solo ignores link", int'(mode), 2);

        // End screen timeout.
        game_over = 1'b1;
        step(1);
        game_over = 1'b0;
        check("endscr", int'(mode), 3);
        n = 0;
        while (mode != MENU && n < 40) begin step(1); n++; end
        check("endscr timeout cycles", n, 16);

        // End screen left early by a click.
        press(2);
        check("solo game again", int'(mode), 2);
        game_over = 1'b1;
        step(1);
        game_over = 1'b0;
        n = 0;
        step(4); n = 4;
        left = 1'b1;
        while (mode != MENU && n < 40) begin step(1); n++; end
        left = 1'b0;
        check("endscr click cycles", n, 8);
        step(6);

        // Non-solo game: game_over beats a simultaneous link drop; then link loss.
        set_pos(450, 300);
        press(2);
        check("solo off", int'(solo), 0);
        link_up = 1'b1;
        set_pos(450, 200);
        press(2);
        check("linked game", int'(mode), 2);
        game_over = 1'b1; link_up = 1'b0;
        step(1);
        game_over = 1'b0;
        check("game_over wins", int'(mode), 3);
        link_up = 1'b1;
        press(2);
        check("endscr click exit", int'(mode), 0);
        press(2);
        check("game again", int'(mode), 2);
        link_up = 1'b0;
        step(2);
        check("link drop mode", int'(mode), 1);
        check("link drop code", int'(err_code), 1);
        check("total start pulses", start_cnt, 5);

        step(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
